// File: rtl/bowling_pkg.sv
// Shared constants and types for the bowling roll sequencer and its roll checker.
package bowling_pkg;

    localparam int FRAMES_DEF = 10;
    localparam int PINS_DEF   = 10;

    typedef enum logic [1:0] {BALL1, BALL2, BALL3, DONE} roll_state_e;

    typedef logic [3:0] pins_t;

endpackage

// File: rtl/bowling_roll_check.sv
// Combinational classification of an offered roll against the pins still standing.
module bowling_roll_check
    import bowling_pkg::*;
#(
    parameter int PINS = PINS_DEF
) (
    input  pins_t       pins,
    input  pins_t       standing,
    input  roll_state_e state,
    output logic        legal,
    output logic        strike,
    output logic        spare
);

    // standing never exceeds PINS, so counts 11..15 always fail this compare
    assign legal  = (state != DONE) && (pins <= standing);
    assign strike = (pins == 4'(PINS));
    assign spare  = (state == BALL2) && (pins == standing);

endmodule

// File: rtl/bowling_frame_sequencer.sv
// Roll sequencer: accepts pin counts, tracks frame/ball/standing incl. tenth-frame bonus balls.
module bowling_frame_sequencer
    import bowling_pkg::*;
#(
    parameter int FRAMES = FRAMES_DEF,
    parameter int PINS   = PINS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       roll_valid,
    input  logic [3:0] pins,
    output logic       roll_ready,
    output logic       upd,
    output logic [3:0] n_out,
    output logic       ft_out,
    output logic       lf_out,
    output logic [3:0] frame,
    output logic [1:0] ball,
    output logic [3:0] standing,
    output logic       err,
    output logic       done
);

    roll_state_e state_q, state_d;
    pins_t       frame_q, frame_d, stand_q, stand_d, n_q, n_d;
    logic [1:0]  ball_q, ball_d;
    logic        strike1_q, strike1_d;
    logic        upd_q, upd_d, err_q, err_d, ft_q, ft_d, lf_q, lf_d;
    logic        legal, strike, spare, accept, last;

    bowling_roll_check #(.PINS(PINS)) u_check (
        .pins    (pins),
        .standing(stand_q),
        .state   (state_q),
        .legal   (legal),
        .strike  (strike),
        .spare   (spare)
    );

    assign accept = roll_valid && (state_q != DONE);
    assign last   = (frame_q == 4'(FRAMES));

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        stand_d   = stand_q;
        strike1_d = strike1_q;
        upd_d     = 1'b0;
        err_d     = 1'b0;
        n_d       = n_q;
        ft_d      = ft_q;
        lf_d      = lf_q;
        if (accept && !legal) begin
            err_d = 1'b1;
        end else if (accept) begin
            upd_d = 1'b1;
            n_d   = pins;
            ft_d  = (state_q == BALL1);
            lf_d  = last;
            case (state_q)
                BALL1: begin
                    if (last) begin
                        state_d   = BALL2;
                        stand_d   = strike ? 4'(PINS) : 4'(PINS) - pins;
                        strike1_d = strike;
                    end else if (strike) begin
                        frame_d = frame_q + 4'd1;
                        stand_d = 4'(PINS);
                    end else begin
                        state_d = BALL2;
                        stand_d = 4'(PINS) - pins;
                    end
                end
                BALL2: begin
                    if (!last) begin
                        state_d = BALL1;
                        frame_d = frame_q + 4'd1;
                        stand_d = 4'(PINS);
                    end else if (strike1_q) begin
                        state_d = BALL3;
                        stand_d = strike ? 4'(PINS) : 4'(PINS) - pins;
                    end else if (spare) begin
                        state_d = BALL3;
                        stand_d = 4'(PINS);
                    end else begin
                        state_d = DONE;
                    end
                end
                BALL3:   state_d = DONE;
                default: ;
            endcase
        end
        // ball keeps its last value once the game is over
        case (state_d)
            BALL1:   ball_d = 2'd1;
            BALL2:   ball_d = 2'd2;
            BALL3:   ball_d = 2'd3;
            default: ball_d = ball_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= BALL1;
            frame_q   <= 4'd1;
            ball_q    <= 2'd1;
            stand_q   <= 4'(PINS);
            strike1_q <= 1'b0;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
            n_q       <= 4'd0;
            ft_q      <= 1'b0;
            lf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            ball_q    <= ball_d;
            stand_q   <= stand_d;
            strike1_q <= strike1_d;
            upd_q     <= upd_d;
            err_q     <= err_d;
            n_q       <= n_d;
            ft_q      <= ft_d;
            lf_q      <= lf_d;
        end
    end

    assign roll_ready = (state_q != DONE);
    assign done       = (state_q == DONE);
    assign upd        = upd_q;
    assign err        = err_q;
    assign n_out      = n_q;
    assign ft_out     = ft_q;
    assign lf_out     = lf_q;
    assign frame      = frame_q;
    assign ball       = ball_q;
    assign standing   = stand_q;

endmodule
